keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan.sv | 138 +++++++++++++
 tb/tb_keypad_scan.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// keypad_scan: row-scanned keypad matrix decoder with frame-level debounce and multi-key detection
module keypad_scan #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4,
  localparam int KW = ($clog2(ROWS * COLS) < 1) ? 1 : $clog2(ROWS * COLS)
) (
  input  logic            clk_1,
  input  logic            rst,
  input  logic [COLS-1:0] columns,
  output logic [ROWS-1:0] rows,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  output logic            key_held,
  output logic            multi_err
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(DEBOUNCE + 1);
  typedef enum logic [1:0] {IDLE, DEB, PRESSED, REL} state_t;
  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [RW-1:0] row_q, row_d;
  logic [1:0]    hits_q, hits_d;
  logic [KW-1:0] first_q, first_d;
  logic [KW-1:0] cand_q, cand_d;
  logic [KW-1:0] key_code_q, key_code_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_valid_q, key_valid_d;
  logic          multi_err_q, multi_err_d;
  logic          sample, frame_end, none, single, same, deb_done;
  logic [1:0]    row_hits, tot;
  logic [KW-1:0] row_first, k;
  logic [CW-1:0] cnt_inc;
  always_comb begin
    row_hits = '0;
    row_first = '0;
    for (int c = COLS - 1; c >= 0; c--)
      if (columns[COLS-1-c]) begin
        row_hits = (row_hits == 2'd2) ? 2'd2 : row_hits + 2'd1;
        row_first = KW'(int'(row_q) * COLS + c);
      end
    tot = (hits_q == 2'd2 || row_hits == 2'd2 || (hits_q == 2'd1 && row_hits == 2'd1)) ? 2'd2 : hits_q | row_hits;
    k = (hits_q == 2'd0) ? row_first : first_q;
    sample = div_q == DW'(SCAN_DIV - 1);
    frame_end = sample && row_q == RW'(ROWS - 1);
    div_d = sample ? '0 : div_q + DW'(1);
    row_d = sample ? ((row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1)) : row_q;
    hits_d = frame_end ? '0 : sample ? tot : hits_q;
    first_d = frame_end ? '0 : sample ? k : first_q;
    multi_err_d = frame_end ? tot == 2'd2 : multi_err_q;
  end
  always_comb begin
    none = tot == 2'd0;
    single = tot == 2'd1;
    same = k == cand_q;
    cnt_inc = cnt_q + CW'(1);
    deb_done = cnt_inc == CW'(DEBOUNCE);
    state_d = state_q;
    cand_d = cand_q;
    cnt_d = cnt_q;
    key_code_d = key_code_q;
    key_valid_d = 1'b0;
    if (frame_end)
      case (state_q)
        IDLE:
          if (single) begin
            cand_d = k;
            if (DEBOUNCE == 1) begin
              state_d = PRESSED;
              key_code_d = k;
              key_valid_d = 1'b1;
              cnt_d = '0;
            end else begin
              state_d = DEB;
              cnt_d = CW'(1);
            end
          end
        DEB:
          if (single && same) begin
            cnt_d = deb_done ? '0 : cnt_inc;
            if (deb_done) begin
              state_d = PRESSED;
              key_code_d = cand_q;
              key_valid_d = 1'b1;
            end
          end else begin
            state_d = IDLE;
            cnt_d = '0;
          end
        PRESSED:
          if (none) begin
            state_d = (DEBOUNCE == 1) ? IDLE : REL;
            cnt_d = (DEBOUNCE == 1) ? '0 : CW'(1);
          end
        REL:
          if (none) begin
            state_d = deb_done ? IDLE : REL;
            cnt_d = deb_done ? '0 : cnt_inc;
          end else begin
            state_d = (single && same) ? PRESSED : REL;
            cnt_d = '0;
          end
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk_1) begin
    if (rst) begin
      state_q <= IDLE;
      div_q <= '0;
      row_q <= '0;
      hits_q <= '0;
      first_q <= '0;
      cand_q <= '0;
      key_code_q <= '0;
      cnt_q <= '0;
      key_valid_q <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      row_q <= row_d;
      hits_q <= hits_d;
      first_q <= first_d;
      cand_q <= cand_d;
      key_code_q <= key_code_d;
      cnt_q <= cnt_d;
      key_valid_q <= key_valid_d;
      multi_err_q <= multi_err_d;
    end
  end
  assign rows = {1'b1, {(ROWS-1){1'b0}}} >> row_q;
  assign key_code = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held = state_q == PRESSED || state_q == REL;
  assign multi_err = multi_err_q;
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed and random frame-level checks of keypad_scan against a frame-history model
module tb_keypad_scan;
  localparam int R = 4, C = 4, SD = 4, D = 3, FR = R * SD;
  logic clk_1 = 1'b0;
  logic rst = 1'b1;
  logic [C-1:0] columns = '0;
  logic [R-1:0] rows;
  logic [3:0] key_code;
  logic key_valid, key_held, multi_err;
  int tests = 0, fails = 0, pos = 0, nvalid = 0;
  logic [15:0] mask = '0;
  bit m_held = 0, m_valid = 0, m_multi = 0;
  int m_streak = 0, m_rel = 0, m_cand = 0;
  logic [3:0] m_code = '0;
  keypad_scan #(.ROWS(R), .COLS(C), .SCAN_DIV(SD), .DEBOUNCE(D)) dut (
    .clk_1(clk_1), .rst(rst), .columns(columns), .rows(rows),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .multi_err(multi_err)
  );
  always #5 clk_1 = ~clk_1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive_cols();
    logic [C-1:0] v;
    int row;
    row = pos / SD;
    v = '0;
    for (int c = 0; c < C; c++) v[C-1-c] = mask[row*C+c];
    columns = (pos % SD == SD - 1) ? v : C'($urandom);
  endtask
  task automatic check_all();
    logic [R-1:0] er;
    er = 4'b1000 >> (pos / SD);
    chk("rows", rows, er);
    chk("key_valid", key_valid, m_valid);
    chk("key_held", key_held, m_held);
    chk("key_code", key_code, m_code);
    chk("multi_err", multi_err, m_multi);
    if (key_valid === 1'b1) nvalid++;
  endtask
  task automatic tick();
    @(posedge clk_1);
    #1;
    pos = rst ? 0 : (pos + 1) % FR;
    drive_cols();
  endtask
  task automatic model_frame(input logic [15:0] m);
    int n, k;
    n = $countones(m);
    k = 0;
    for (int i = 15; i >= 0; i--) if (m[i]) k = i;
    m_multi = n >= 2;
    if (!m_held) begin
      if (n == 1 && (m_streak == 0 || k == m_cand)) begin
        if (m_streak == 0) m_cand = k;
        m_streak++;
        if (m_streak == D) begin
          m_held = 1;
          m_valid = 1;
          m_code = 4'(m_cand);
          m_streak = 0;
        end
      end else m_streak = 0;
    end else if (n == 0) begin
      m_rel++;
      if (m_rel == D) begin
        m_held = 0;
        m_rel = 0;
      end
    end else m_rel = 0;
  endtask
  task automatic frame(input logic [15:0] m);
    mask = m;
    drive_cols();
    for (int i = 0; i < FR; i++) begin
      tick();
      m_valid = 0;
      if (i == FR - 1) model_frame(m);
      check_all();
    end
  endtask
  task automatic partial(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      m_valid = 0;
      check_all();
    end
  endtask
  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_held = 0;
    m_valid = 0;
    m_multi = 0;
    m_streak = 0;
    m_rel = 0;
    m_cand = 0;
    m_code = '0;
    check_all();
  endtask
  initial begin
    int hold, sel, a, b;
    logic [15:0] pat;
    reset_pulse();
    frame(16'h0000);
    frame(16'h0000);
    nvalid = 0;
    frame(16'h0040);
    frame(16'h0040);
    frame(16'h0040);
    chk("r031_code", key_code, 4'd6);
    chk("r031_pulses", nvalid, 1);
    frame(16'h0000);
    frame(16'h0000);
    frame(16'h0000);
    chk("r034_release", key_held, 1'b0);
    nvalid = 0;
    frame(16'h0040);
    frame(16'h0040);
    frame(16'h0000);
    frame(16'h0040);
    frame(16'h0040);
    chk("r032_no_early", nvalid, 0);
    frame(16'h0040);
    chk("r032_pulses", nvalid, 1);
    frame(16'h0000);
    frame(16'h0040);
    frame(16'h0040);
    chk("r034_still_held", key_held, 1'b1);
    chk("r034_pulses", nvalid, 1);
    frame(16'h0000);
    frame(16'h0000);
    frame(16'h0000);
    nvalid = 0;
    frame(16'h0801);
    chk("r033_multi", multi_err, 1'b1);
    frame(16'h0801);
    frame(16'h0801);
    chk("r033_no_valid", nvalid, 0);
    chk("r033_idle", key_held, 1'b0);
    frame(16'h0000);
    chk("r033_clear", multi_err, 1'b0);
    frame(16'h2000);
    frame(16'h2000);
    frame(16'h2000);
    chk("r035_held", key_held, 1'b1);
    mask = 16'h2000;
    partial(5);
    nvalid = 0;
    reset_pulse();
    chk("r035_rst_held", key_held, 1'b0);
    frame(16'h2000);
    frame(16'h2000);
    frame(16'h2000);
    chk("r035_revalid", nvalid, 1);
    chk("r035_code", key_code, 4'd13);
    hold = 0;
    pat = '0;
    for (int f = 0; f < 80; f++) begin
      if (hold == 0) begin
        sel = $urandom_range(0, 5);
        a = $urandom_range(0, 15);
        b = (a + 1 + $urandom_range(0, 14)) % 16;
        pat = (sel < 2) ? 16'h0 : (sel < 5) ? (16'h1 << a) : ((16'h1 << a) | (16'h1 << b));
        hold = $urandom_range(1, 5);
      end
      frame(pat);
      hold--;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
